// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - MEM_B / MEM_H / MEM_W : access size encodings (2'b11 is illegal)
//   - state_t               : responder FSM states
//   - is_aligned()          : legality of a size/offset pair
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [1:0] MEM_B = 2'b00;
   localparam logic [1:0] MEM_H = 2'b01;
   localparam logic [1:0] MEM_W = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // True when the size code is legal and the byte offset suits it.
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
      logic ok;
      case (size)
         MEM_B:   ok = 1'b1;
         MEM_H:   ok = ~off[0];
         MEM_W:   ok = (off == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering.
// Store side:
//   i_st_size, i_st_off, i_st_wdata -> o_st_be (byte enables), o_st_data (data
//   shifted into its lanes)
// Load side:
//   i_ld_word, i_ld_size, i_ld_off, i_ld_unsigned -> o_ld_data (extracted and
//   sign/zero-extended value)
// -----------------------------------------------------------------------------
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  i_st_size,
   input  logic [1:0]  i_st_off,
   input  logic [31:0] i_st_wdata,
   output logic [3:0]  o_st_be,
   output logic [31:0] o_st_data,
   input  logic [31:0] i_ld_word,
   input  logic [1:0]  i_ld_size,
   input  logic [1:0]  i_ld_off,
   input  logic        i_ld_unsigned,
   output logic [31:0] o_ld_data
);

   logic [31:0] w_ld_shifted;
   logic        w_ext_b;
   logic        w_ext_h;

   always_comb begin
      o_st_data = i_st_wdata << {i_st_off, 3'b000};
      o_st_be   = 4'b0000;
      case (i_st_size)
         MEM_B:   o_st_be = 4'b0001 << i_st_off;
         MEM_H:   o_st_be = 4'b0011 << i_st_off;
         MEM_W:   o_st_be = 4'b1111;
         default: o_st_be = 4'b0000;
      endcase
   end

   // Bring the addressed lane down to bit 0, then extend.
   assign w_ld_shifted = i_ld_word >> {i_ld_off, 3'b000};
   assign w_ext_b      = ~i_ld_unsigned & w_ld_shifted[7];
   assign w_ext_h      = ~i_ld_unsigned & w_ld_shifted[15];

   always_comb begin
      o_ld_data = w_ld_shifted;
      case (i_ld_size)
         MEM_B:   o_ld_data = {{24{w_ext_b}}, w_ld_shifted[7:0]};
         MEM_H:   o_ld_data = {{16{w_ext_h}}, w_ld_shifted[15:0]};
         default: o_ld_data = w_ld_shifted;   // word: offset is 0 when legal
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// One request at a time over valid/ready; response LATENCY cycles after accept.
//
// Parameters: DEPTH_WORDS (32-bit words of storage), LATENCY (1..15).
// Ports:
//   clk, rst                 clock / asynchronous active-high reset
//   i_req_valid, o_req_ready request handshake
//   i_req_we, i_req_addr, i_req_wdata, i_req_size, i_req_unsigned  request
//   o_rsp_valid, i_rsp_ready response handshake
//   o_rsp_rdata, o_rsp_err   response payload
// Optional (macro DMEM_STATS_EN):
//   o_stat_loads, o_stat_stores, o_stat_errs  32-bit wrapping access counters
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [1:0]  i_req_size,
   input  logic        i_req_unsigned,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err
`ifdef DMEM_STATS_EN
   ,
   output logic [31:0] o_stat_loads,
   output logic [31:0] o_stat_stores,
   output logic [31:0] o_stat_errs
`endif
);

   localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

   state_t      r_state, w_state_next;
   logic [3:0]  r_cnt, w_cnt_next;
   logic        w_accept;

   // Request fields captured at the accept edge for the response phase.
   logic        r_is_load;
   logic        r_err;
   logic [1:0]  r_size;
   logic [1:0]  r_off;
   logic        r_unsigned;

   logic [IDX_W-1:0] w_idx;
   logic        w_in_range;
   logic        w_req_err;
   logic        w_write;
   logic [3:0]  w_be;
   logic [31:0] w_st_data;
   logic [31:0] w_raw_word;
   logic [31:0] w_ld_data;

   assign w_idx      = i_req_addr[IDX_W+1:2];
   assign w_in_range = ({2'b00, i_req_addr[31:2]} < 32'(DEPTH_WORDS));
   assign w_req_err  = ~is_aligned(i_req_size, i_req_addr[1:0]) | ~w_in_range;
   assign w_write    = w_accept & i_req_we & ~w_req_err;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_accept     = 1'b0;
      o_req_ready  = 1'b0;
      o_rsp_valid  = 1'b0;
      o_rsp_rdata  = 32'd0;
      o_rsp_err    = 1'b0;
      case (r_state)
         IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               w_accept   = 1'b1;
               w_cnt_next = LAT_INIT;
               w_state_next = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            // Leaving on the decrement that reaches zero puts rsp_valid
            // exactly LATENCY cycles after the accept edge.
            w_cnt_next = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
               w_cnt_next   = 4'd0;
               w_state_next = RESP;
            end
         end
         RESP: begin
            o_rsp_valid = 1'b1;
            o_rsp_err   = r_err;
            if (r_is_load && !r_err)
               o_rsp_rdata = w_ld_data;
            if (i_rsp_ready)
               w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------- request capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_is_load  <= 1'b0;
         r_err      <= 1'b0;
         r_size     <= MEM_B;
         r_off      <= 2'b00;
         r_unsigned <= 1'b0;
      end else if (w_accept) begin
         r_is_load  <= ~i_req_we;
         r_err      <= w_req_err;
         r_size     <= i_req_size;
         r_off      <= i_req_addr[1:0];
         r_unsigned <= i_req_unsigned;
      end
   end

`ifdef DMEM_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_stat_loads  <= 32'd0;
         o_stat_stores <= 32'd0;
         o_stat_errs   <= 32'd0;
      end else if (w_accept) begin
         if (w_req_err)
            o_stat_errs <= o_stat_errs + 32'd1;
         else if (i_req_we)
            o_stat_stores <= o_stat_stores + 32'd1;
         else
            o_stat_loads <= o_stat_loads + 32'd1;
      end
   end
`endif

   // ------------------------------------------------------------ storage
   // One byte-wide array per lane so each lane maps onto a plain RAM with a
   // registered read. Storage is deliberately not reset.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] r_mem [DEPTH_WORDS];
         logic [7:0] r_rd_byte;

         always_ff @(posedge clk) begin
            if (w_accept) begin
               if (w_write && w_be[gi])
                  r_mem[w_idx] <= w_st_data[8*gi +: 8];
               r_rd_byte <= r_mem[w_idx];
            end
         end

         assign w_raw_word[8*gi +: 8] = r_rd_byte;
      end
   endgenerate

   dmem_lane_align u_lane_align (
      .i_st_size     (i_req_size),
      .i_st_off      (i_req_addr[1:0]),
      .i_st_wdata    (i_req_wdata),
      .o_st_be       (w_be),
      .o_st_data     (w_st_data),
      .i_ld_word     (w_raw_word),
      .i_ld_size     (r_size),
      .i_ld_off      (r_off),
      .i_ld_unsigned (r_unsigned),
      .o_ld_data     (w_ld_data)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed self-checking bench for dmem_responder (LATENCY=3, 256 words).
// Each transaction is driven on a falling edge, accepted on the next rising
// edge, and its response is sampled on falling edges.
// Optional: DMEM_STATS_EN enables checks of the statistics counters.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 3;

   localparam logic [1:0] SB = 2'b00;
   localparam logic [1:0] SH = 2'b01;
   localparam logic [1:0] SW = 2'b10;
   localparam logic [1:0] SX = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
`ifdef DMEM_STATS_EN
   logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_we       (req_we),
      .i_req_addr     (req_addr),
      .i_req_wdata    (req_wdata),
      .i_req_size     (req_size),
      .i_req_unsigned (req_unsigned),
      .o_rsp_valid    (rsp_valid),
      .i_rsp_ready    (rsp_ready),
      .o_rsp_rdata    (rsp_rdata),
      .o_rsp_err      (rsp_err)
`ifdef DMEM_STATS_EN
      ,
      .o_stat_loads   (stat_loads),
      .o_stat_stores  (stat_stores),
      .o_stat_errs    (stat_errs)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // One complete request/response. 'hold' keeps rsp_ready low for that many
   // cycles while junk requests are offered, which must all be ignored.
   task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
      int lat;
      @(negedge clk);
      chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
      req_valid    = 1'b1;
      req_we       = we;
      req_addr     = addr;
      req_wdata    = wdata;
      req_size     = size;
      req_unsigned = uns;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_size  = 2'($urandom_range(0, 3));
      req_unsigned = 1'($urandom_range(0, 1));
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 40);
      chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, ".latency"}, 32'(lat), 32'(LAT));
      chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
      chk({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      $display("xact %s we=%0b addr=%h wdata=%h size=%0d uns=%0b -> rdata=%h err=%0b lat=%0d",
               tag, we, addr, wdata, size, uns, rsp_rdata, rsp_err, lat);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         req_we    = 1'b1;
         req_addr  = 32'h0000_0010;
         req_wdata = 32'h0000_0000;
         req_size  = SW;
         @(negedge clk);
         chk({tag, ".hold.valid"}, {31'd0, rsp_valid}, 32'd1);
         chk({tag, ".hold.rdata"}, rsp_rdata, exp_rdata);
         chk({tag, ".hold.req_ready"}, {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk({tag, ".after.req_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, ".after.rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset
      repeat (3) @(negedge clk);
      chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst.rdata", rsp_rdata, 32'd0);
      chk("rst.err", {31'd0, rsp_err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst.req_ready", {31'd0, req_ready}, 32'd1);
      chk("post_rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
`ifdef DMEM_STATS_EN
      chk("rst.stat_loads", stat_loads, 32'd0);
      chk("rst.stat_stores", stat_stores, 32'd0);
      chk("rst.stat_errs", stat_errs, 32'd0);
`endif

      // ---- byte extension
      xact("st_w_10",  1, 32'h10, 32'h80FF7F01, SW, 0, 32'h0, 0, 0);
      xact("ld_b_13s", 0, 32'h13, 32'h0, SB, 0, 32'hFFFFFF80, 0, 0);
      xact("ld_b_13u", 0, 32'h13, 32'h0, SB, 1, 32'h00000080, 0, 0);
      xact("ld_b_10s", 0, 32'h10, 32'h0, SB, 0, 32'h00000001, 0, 0);
      xact("ld_b_11s", 0, 32'h11, 32'h0, SB, 0, 32'h0000007F, 0, 0);
      xact("ld_b_12s", 0, 32'h12, 32'h0, SB, 0, 32'hFFFFFFFF, 0, 0);
      xact("ld_b_12u", 0, 32'h12, 32'h0, SB, 1, 32'h000000FF, 0, 0);
      xact("ld_w_10u", 0, 32'h10, 32'h0, SW, 1, 32'h80FF7F01, 0, 0);

      // ---- half merge and byte merge
      xact("st_w_20",  1, 32'h20, 32'h11223344, SW, 0, 32'h0, 0, 0);
      xact("st_h_22",  1, 32'h22, 32'h1234BEEF, SH, 0, 32'h0, 0, 0);
      xact("ld_w_20",  0, 32'h20, 32'h0, SW, 0, 32'hBEEF3344, 0, 0);
      xact("ld_h_22s", 0, 32'h22, 32'h0, SH, 0, 32'hFFFFBEEF, 0, 0);
      xact("ld_h_22u", 0, 32'h22, 32'h0, SH, 1, 32'h0000BEEF, 0, 0);
      xact("ld_h_20s", 0, 32'h20, 32'h0, SH, 0, 32'h00003344, 0, 0);
      xact("st_b_21",  1, 32'h21, 32'hFFFFFFAB, SB, 0, 32'h0, 0, 0);
      xact("ld_w_20b", 0, 32'h20, 32'h0, SW, 0, 32'hBEEFAB44, 0, 0);

      // ---- errors
      xact("st_w_00",   1, 32'h00, 32'h01020304, SW, 0, 32'h0, 0, 0);
      xact("err_ld_w6", 0, 32'h06, 32'h0, SW, 0, 32'h0, 1, 0);
      xact("err_ld_h11",0, 32'h11, 32'h0, SH, 0, 32'h0, 1, 0);
      xact("err_st_oor",1, 32'(DEPTH * 4), 32'hDEADDEAD, SW, 0, 32'h0, 1, 0);
      xact("ld_w_00",   0, 32'h00, 32'h0, SW, 0, 32'h01020304, 0, 0);
      xact("err_size11",0, 32'h10, 32'h0, SX, 0, 32'h0, 1, 0);
      xact("err_st_w22",1, 32'h22, 32'hFFFFFFFF, SW, 0, 32'h0, 1, 0);
      xact("ld_w_20c",  0, 32'h20, 32'h0, SW, 0, 32'hBEEFAB44, 0, 0);

      // ---- backpressure with ignored requests
      xact("bp_ld_w10", 0, 32'h10, 32'h0, SW, 0, 32'h80FF7F01, 0, 5);
      xact("ld_w_10b",  0, 32'h10, 32'h0, SW, 0, 32'h80FF7F01, 0, 0);

      // ---- reset during WAIT; committed store survives
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h40;
      req_wdata = 32'hA5A5A5A5;
      req_size  = SW;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      @(negedge clk);
      chk("midrst.in_wait", {31'd0, req_ready}, 32'd0);
      rst = 1'b1;
      #1;
      chk("midrst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midrst.req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst.idle.rsp_valid", {31'd0, rsp_valid}, 32'd0);
`ifdef DMEM_STATS_EN
      chk("midrst.stat_stores", stat_stores, 32'd0);
      chk("midrst.stat_loads", stat_loads, 32'd0);
`endif
      xact("ld_w_40", 0, 32'h40, 32'h0, SW, 0, 32'hA5A5A5A5, 0, 0);
`ifdef DMEM_STATS_EN
      chk("final.stat_loads", stat_loads, 32'd1);
      chk("final.stat_stores", stat_stores, 32'd0);
      chk("final.stat_errs", stat_errs, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the pipeline's MEM-stage load/store port.
- Accepts one load/store request at a time over a valid/ready handshake.
- Models a fixed multi-cycle access latency, handles byte/half/word lanes, and sign/zero-extends loads.
- Returns the result on a valid/ready response channel; replaces the single-cycle combinational data RAM.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in storage. Word index = req_addr[31:2].
- LATENCY, 2: cycles from the accept edge to rsp_valid rising. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal-size request.

Behaviour:
- Reset values: FSM in IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, the request is accepted at that edge.
  - After accept: go to WAIT with counter=LATENCY-1. If LATENCY=1, go straight to RESP.
  - WAIT: req_ready=0. Counter decrements each cycle; on reaching 0, go to RESP.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err held stable. On rsp_ready, return to IDLE.
- Timing: rsp_valid rises exactly LATENCY cycles after the accept edge. Next request can be accepted the cycle after the response handshake. Peak throughput is one access per LATENCY+1 cycles.
- Accept edge actions:
  - Error check runs first.
  - Stores write the selected byte lanes to storage at this edge.
  - Loads read the addressed word at this edge and latch the extracted, extended value into a result register. A store's effect is visible to the next request.
- Lane rules, with o = req_addr[1:0]:
  - Byte: lane o. Half: lanes o and o+1. Word: all four lanes.
  - Store data is shifted left by 8*o.
  - Load byte: bit 7 of the extracted value is replicated unless req_unsigned=1. Load half: bit 15 is replicated under the same rule. Load word: req_unsigned is ignored.
- Error conditions: half with o[0]=1; word with o!=0; req_size=11; req_addr[31:2] >= DEPTH_WORDS.
- On error: no storage write, rsp_rdata=0, rsp_err=1. Latency is unchanged.
- Stores: rsp_rdata=0 and rsp_err=0 when legal.
- Backpressure: while rsp_ready=0, the FSM stays in RESP indefinitely with outputs stable.
- Inputs are ignored outside IDLE.
- Reset mid-operation: any pending response is dropped and the FSM returns to IDLE. A store already committed at its accept edge remains in storage.

Optional Feature:
- Macro: DMEM_STATS_EN.
- When defined, adds three 32-bit outputs: stat_loads, stat_stores, stat_errs.
  - Counters increment at the accept edge of a legal load, a legal store, and an erroring request respectively.
  - They reset to 0 on rst and wrap modulo 2^32.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package dmem_pkg holds:
  - Size encoding constants MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10.
  - FSM state typedef {IDLE, WAIT, RESP}.
  - A function checking alignment legality.
- One natural sub-module: dmem_lane_align, combinational. It produces:
  - Byte enables and shifted store data from size, offset and wdata.
  - Extracted, extended load data from the raw word, size, offset and unsigned flag.

Test Plan:
- Reset → ready: assert rst, release → req_ready=1, rsp_valid=0, rsp_rdata=0.
- Byte store/load sign and zero extend: store word 0x80FF7F01 at 0x10 (size 10), then load byte at 0x13 signed → rsp_rdata=0xFFFFFF80, rsp_err=0; load byte at 0x13 with req_unsigned=1 → 0x00000080.
- Half store merge: with word 0x11223344 at 0x20, store half 0xBEEF at 0x22, then load word 0x20 → 0xBEEF3344; load half 0x22 signed → 0xFFFFBEEF.
- Latency and backpressure: LATENCY=3, accept a load at cycle t → rsp_valid rises at t+3. Hold rsp_ready=0 for 5 cycles → data stable and req_ready=0; handshake → req_ready=1 next cycle.
- Errors: word load at 0x06 → rsp_err=1, rsp_rdata=0. Store to word index DEPTH_WORDS → rsp_err=1, and a later load of index 0 shows it unchanged. size=11 → rsp_err=1.
- Reset mid-WAIT: accept a store of 0xA5A5A5A5 to 0x40, assert rst during WAIT → rsp_valid=0, FSM in IDLE. Load 0x40 → 0xA5A5A5A5. With DMEM_STATS_EN: stat_stores=0 after reset, 0 loads → stat_loads=1 after the reload.
